// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time byte-stream loader for the MIPS32 core memory.
//                Packs big-endian bytes into words, writes them, then releases
//                the core. Optional trailing XOR checksum: LOADER_CSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_run,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    localparam logic [2:0] c_ST_LEN_HI = 3'd0;
    localparam logic [2:0] c_ST_LEN_LO = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef LOADER_CSUM_EN
    localparam logic [2:0] c_ST_CSUM   = 3'd3;
`endif
    localparam logic [2:0] c_ST_RUN    = 3'd4;
    localparam logic [2:0] c_ST_ERR    = 3'd5;

    localparam logic [16:0] c_MAX_LEN  = 17'(MEM_WORDS);

    logic [2:0]    state_q, state_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [AW:0]   len_q, len_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW:0]   word_idx_q, word_idx_d;
    logic [23:0]   asm_q, asm_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [AW:0]   words_loaded_q, words_loaded_d;
    logic          cpu_run_q;
    logic          done_q;
    logic          err_q;
`ifdef LOADER_CSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          w_busy;
    logic          w_accept;
    logic [16:0]   w_len;
    logic          w_len_bad;
    logic [AW:0]   w_idx_nxt;

    always_comb begin
        w_busy = 1'b0;
        case (state_q)
            c_ST_LEN_HI,
            c_ST_LEN_LO,
            c_ST_DATA:   w_busy = 1'b1;
`ifdef LOADER_CSUM_EN
            c_ST_CSUM:   w_busy = 1'b1;
`endif
            default:     w_busy = 1'b0;
        endcase
    end

    assign s_ready   = w_busy & ~rst;
    assign w_accept  = s_valid & s_ready;
    assign w_len     = {1'b0, len_hi_q, s_data};
    assign w_len_bad = (w_len == 17'd0) || (w_len > c_MAX_LEN);
    assign w_idx_nxt = word_idx_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        len_hi_d       = len_hi_q;
        len_d          = len_q;
        byte_cnt_d     = byte_cnt_q;
        word_idx_d     = word_idx_q;
        asm_d          = asm_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;
`ifdef LOADER_CSUM_EN
        csum_d         = csum_q;
`endif
        if (w_accept) begin
            case (state_q)
                c_ST_LEN_HI: begin
                    len_hi_d = s_data;
                    state_d  = c_ST_LEN_LO;
                end
                c_ST_LEN_LO: begin
                    if (w_len_bad) begin
                        state_d = c_ST_ERR;
                    end else begin
                        len_d      = w_len[AW:0];
                        byte_cnt_d = 2'd0;
                        word_idx_d = '0;
`ifdef LOADER_CSUM_EN
                        csum_d     = 8'd0;
`endif
                        state_d    = c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    asm_d      = {asm_q[15:0], s_data};
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef LOADER_CSUM_EN
                    csum_d     = csum_q ^ s_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d       = 1'b1;
                        mem_addr_d     = word_idx_q[AW-1:0];
                        mem_wdata_d    = {asm_q, s_data};
                        word_idx_d     = w_idx_nxt;
                        words_loaded_d = w_idx_nxt;
                        // The final word leaves DATA, so the index never passes N.
                        if (w_idx_nxt == len_q) begin
`ifdef LOADER_CSUM_EN
                            state_d = c_ST_CSUM;
`else
                            state_d = c_ST_RUN;
`endif
                        end
                    end
                end
`ifdef LOADER_CSUM_EN
                c_ST_CSUM: begin
                    state_d = (s_data == csum_q) ? c_ST_RUN : c_ST_ERR;
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Status flags follow the state one edge later, so the final write lands
    // before the core sees cpu_run.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q        <= c_ST_LEN_HI;
            len_hi_q       <= 8'd0;
            len_q          <= '0;
            byte_cnt_q     <= 2'd0;
            word_idx_q     <= '0;
            asm_q          <= 24'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            words_loaded_q <= '0;
            cpu_run_q      <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q         <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            len_hi_q       <= len_hi_d;
            len_q          <= len_d;
            byte_cnt_q     <= byte_cnt_d;
            word_idx_q     <= word_idx_d;
            asm_q          <= asm_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            words_loaded_q <= words_loaded_d;
            cpu_run_q      <= (state_q == c_ST_RUN);
            done_q         <= (state_q == c_ST_RUN);
            err_q          <= (state_q == c_ST_ERR);
`ifdef LOADER_CSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Scoreboard bench for prog_loader (honours LOADER_CSUM_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int MEM_WORDS = 1024;
    localparam int AW        = 10;

    logic          clk1 = 1'b0;
    logic          rst  = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data  = 8'd0;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    prog_loader #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_dut (
        .clk1         (clk1),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk1 = ~clk1;

    int n_chk  = 0;
    int n_pass = 0;
    logic [41:0] exp_q[$];
    logic        prev_we = 1'b0;
    logic [31:0] words [0:15];
    logic [7:0]  csum_model;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Write monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            chk("we_adjacent", {63'd0, prev_we}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {54'd0, mem_addr, mem_wdata}, 64'd0);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {54'd0, mem_addr}, {54'd0, e[41:32]});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
            end
        end
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps && ($urandom_range(1, 0) == 1)) begin
            s_valid = 1'b0;
            @(posedge clk1); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk1); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk1); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        chk("rst_outputs", {48'd0, s_ready, mem_we, mem_addr, cpu_run, done, err},
            64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_words", {53'd0, words_loaded}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, s_ready}, 64'd1);
    endtask

    // Sends length and payload; the trailing checksum is left to the caller.
    task automatic send_payload(input int n, input bit gaps);
        send_byte(8'(n >> 8), gaps);
        send_byte(8'(n), gaps);
        csum_model = 8'd0;
        for (int w = 0; w < n; w++) begin
            for (int k = 3; k >= 0; k--) begin
                logic [7:0] b;
                b = 8'(words[w] >> (8 * k));
                csum_model = csum_model ^ b;
                if (k == 0) exp_q.push_back({10'(w), words[w]});
                send_byte(b, gaps);
            end
        end
    endtask

    task automatic expect_run(input int n);
        repeat (2) @(posedge clk1);
        #1;
        chk("run_cpu_run", {63'd0, cpu_run}, 64'd1);
        chk("run_done", {63'd0, done}, 64'd1);
        chk("run_err", {63'd0, err}, 64'd0);
        chk("run_ready", {63'd0, s_ready}, 64'd0);
        chk("run_words", {53'd0, words_loaded}, 64'(n));
    endtask

    task automatic expect_err(input int n);
        repeat (2) @(posedge clk1);
        #1;
        chk("err_flag", {63'd0, err}, 64'd1);
        chk("err_cpu_run", {63'd0, cpu_run}, 64'd0);
        chk("err_ready", {63'd0, s_ready}, 64'd0);
        chk("err_words", {53'd0, words_loaded}, 64'(n));
    endtask

    task automatic poke_ignored();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (6) @(posedge clk1);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // Two-word image
        words[0] = 32'h2001000A;
        words[1] = 32'hFC000000;
        send_payload(2, 1'b0);
`ifdef LOADER_CSUM_EN
        send_byte(csum_model, 1'b0);
`endif
        expect_run(2);
        poke_ignored();
        chk("run_sticky", {62'd0, cpu_run, done}, 64'd3);

`ifdef LOADER_CSUM_EN
        // Bad checksum: words written, core never released
        do_reset();
        send_payload(2, 1'b0);
        send_byte(8'hDD, 1'b0);
        expect_err(2);
        poke_ignored();
        chk("err_sticky", {62'd0, err, cpu_run}, 64'd2);
`endif

        // Illegal lengths
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        expect_err(0);
        do_reset();
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        expect_err(0);

        // Largest legal length is accepted
        do_reset();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (2) @(posedge clk1);
        #1;
        chk("max_len_ok", {62'd0, err, s_ready}, 64'd1);

        // 16 words with a random valid pattern
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        send_payload(16, 1'b1);
`ifdef LOADER_CSUM_EN
        send_byte(csum_model, 1'b1);
`endif
        expect_run(16);

        // Reset in the middle of word 1, then a fresh single-word load
        do_reset();
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h01020304;
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        exp_q.push_back({10'd0, 32'hDEADBEEF});
        for (int k = 3; k >= 0; k--) send_byte(8'(words[0] >> (8 * k)), 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        do_reset();
        words[0] = 32'h11223344;
        send_payload(1, 1'b0);
        chk("last_we_high", {62'd0, mem_we, cpu_run}, 64'd2);
`ifdef LOADER_CSUM_EN
        send_byte(csum_model, 1'b0);
        chk("csum_run_low", {63'd0, cpu_run}, 64'd0);
`endif
        @(posedge clk1); #1;
        chk("run_rise", {61'd0, cpu_run, done, mem_we}, 64'd6);
        expect_run(1);

        repeat (3) @(posedge clk1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
